// File: rtl/seg_scan_mux_if.sv
// Purpose : bundles the time-field inputs, blink select and display drive
//           outputs of seg_scan_mux into one port.
// Ports   : six packed-BCD time fields, blink_sel (in); an, seg, dp, frame_done (out)
// Modports: master drives the time fields and reads the display; slave is the mux.
interface seg_scan_mux_if;
    // Time fields, two packed BCD digits each: [7:4] tens, [3:0] ones
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic [7:0]  hour_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  month_bcd;
    logic [7:0]  year_bcd;
    // Field to blink: 1 sec .. 6 year, 0/7 none
    logic [2:0]  blink_sel;
    // Active-low display drive
    logic [11:0] an;
    logic [6:0]  seg;
    logic        dp;
    // Single-cycle pulse on the last cycle of each scan frame
    logic        frame_done;

    modport master (
        output sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd, year_bcd, blink_sel,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd, year_bcd, blink_sel,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Purpose : 12-digit multiplexed 7-segment driver for a sec/min/hour/day/month/year clock.
// Latency : an/seg/dp follow the digit index by one clk; inputs appear from the next frame.
// Backpressure: none -- free-running scan; input fields are sampled once per frame.
//
// Ports:
//   clk  - single clock, all state updates on its rising edge
//   rst  - asynchronous, active-high reset
//   bus  - seg_scan_mux_if.slave: BCD fields + blink_sel in, an/seg/dp/frame_done out
// Parameters:
//   REFRESH_DIV  - clk cycles each digit stays selected (>= 2)
//   BLINK_FRAMES - full scan frames per blink phase (>= 1)
// Build option:
//   SEG_SCAN_BLINK_EN - when defined, the field selected by blink_sel is blanked
//                       during every other group of BLINK_FRAMES frames. When not
//                       defined, blink_sel is ignored and nothing is ever blanked.
//
// Slot map (even = ones digit, odd = tens digit):
//   0/1 sec, 2/3 min, 4/5 hour, 6/7 day, 8/9 month, 10/11 year
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // REFRESH_DIV >= 2 guarantees at least one prescaler bit.
    localparam int              PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]      IDX_LAST   = 4'd11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [3:0]    idx_q;

    // Frame-stable copies of the time fields
    logic [7:0]    sec_sh_q;
    logic [7:0]    min_sh_q;
    logic [7:0]    hour_sh_q;
    logic [7:0]    day_sh_q;
    logic [7:0]    month_sh_q;
    logic [7:0]    year_sh_q;

    // Registered display drive
    logic [11:0]   an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic          scan_tick;    // prescaler wraps: digit index advances
    logic          frame_wrap;   // scan tick on the last slot: frame boundary
    logic [2:0]    field_idx;    // 0 sec .. 5 year
    logic [2:0]    field_num;    // 1 sec .. 6 year, same encoding as blink_sel
    logic [7:0]    field_bcd;
    logic [3:0]    nibble;
    logic [11:0]   an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          blank;

    assign scan_tick  = (presc_q == PRESC_LAST);
    assign frame_wrap = scan_tick && (idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // Prescaler: 0 .. REFRESH_DIV-1, wrapping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (scan_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit index: 0 .. 11, advancing once per scan tick
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (scan_tick) begin
            if (frame_wrap) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture
    // All six fields are sampled on the same edge that returns the index
    // to slot 0, so a whole frame is drawn from one consistent snapshot
    // and a rollover (e.g. 23:59:59 -> 00:00:00) never shows half-applied.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_sh_q   <= '0;
            min_sh_q   <= '0;
            hour_sh_q  <= '0;
            day_sh_q   <= '0;
            month_sh_q <= '0;
            year_sh_q  <= '0;
        end else if (frame_wrap) begin
            sec_sh_q   <= bus.sec_bcd;
            min_sh_q   <= bus.min_bcd;
            hour_sh_q  <= bus.hour_bcd;
            day_sh_q   <= bus.day_bcd;
            month_sh_q <= bus.month_bcd;
            year_sh_q  <= bus.year_bcd;
        end
    end

    // ------------------------------------------------------------------
    // Blink phase
    // ------------------------------------------------------------------
`ifdef SEG_SCAN_BLINK_EN
    localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt_q;
    logic          blink_phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q   <= frame_cnt_q + 1'b1;
            end
        end
    end

    // blink_sel is used live, so a new selection shows on the very next
    // output update. Values 0 and 7 can never equal field_num (1..6).
    assign blank = blink_phase_q && (bus.blink_sel == field_num);
`else
    logic unused_blink_sel;

    assign unused_blink_sel = ^bus.blink_sel;
    assign blank            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Current digit selection
    // ------------------------------------------------------------------
    assign field_idx = idx_q[3:1];
    assign field_num = field_idx + 3'd1;

    always_comb begin
        field_bcd = 8'h00;
        case (field_idx)
            3'd0:    field_bcd = sec_sh_q;
            3'd1:    field_bcd = min_sh_q;
            3'd2:    field_bcd = hour_sh_q;
            3'd3:    field_bcd = day_sh_q;
            3'd4:    field_bcd = month_sh_q;
            3'd5:    field_bcd = year_sh_q;
            default: field_bcd = 8'h00;
        endcase
    end

    assign nibble = idx_q[0] ? field_bcd[7:4] : field_bcd[3:0];

    // ------------------------------------------------------------------
    // BCD to 7-segment, active low, bit order g..a.
    // Non-BCD nibbles show a dash so a bad input is visible on the display.
    // ------------------------------------------------------------------
    always_comb begin
        seg_nxt = 7'b0111111;
        case (nibble)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b0111111;
        endcase
    end

    // One-cold anode for the current slot
    assign an_nxt = ~(12'h001 << idx_q);

    // Decimal points separate fields: after the ones digits of min, hour,
    // day and month.
    always_comb begin
        dp_nxt = 1'b1;
        case (idx_q)
            4'd2, 4'd4, 4'd6, 4'd8: dp_nxt = 1'b0;
            default:                dp_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers: updated every cycle so that an, seg and dp change
    // together one clock after the index does.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 12'hFFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= blank ? 12'hFFF : an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    // Prescaler resets to 0, so this stays low throughout reset.
    assign bus.frame_done = frame_wrap;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Purpose : directed check of seg_scan_mux with REFRESH_DIV=4, BLINK_FRAMES=2.
// Timing  : after reset release, output edge n shows slot ((n-1)/4) mod 12;
//           a frame is 48 clocks and frame f starts at edge 48*f.
module tb_seg_scan_mux;

`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   vec_cnt;
    int   err_cnt;

    seg_scan_mux_if bus();

    seg_scan_mux #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the falling edge after rising edge n
    task automatic at_edge(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Expected an/dp come from the slot number; seg is hand-decoded by caller
    task automatic check_slot(input string tag, input int slot,
                              input logic [6:0] exp_seg, input bit exp_blank);
        logic [11:0] exp_an;
        logic        exp_dp;
        exp_an = exp_blank ? 12'hFFF : (12'hFFF ^ (12'h001 << slot));
        exp_dp = (slot == 2 || slot == 4 || slot == 6 || slot == 8) ? 1'b0 : 1'b1;
        check({tag, "_an"},  32'(bus.an),  32'(exp_an));
        check({tag, "_seg"}, 32'(bus.seg), 32'(exp_seg));
        check({tag, "_dp"},  32'(bus.dp),  32'(exp_dp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  32'(bus.an),         32'h0FFF);
        check({tag, "_seg"}, 32'(bus.seg),        32'h7F);
        check({tag, "_dp"},  32'(bus.dp),         32'h1);
        check({tag, "_fd"},  32'(bus.frame_done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        bus.sec_bcd   = 8'h59;
        bus.min_bcd   = 8'h12;
        bus.hour_bcd  = 8'hA3;
        bus.day_bcd   = 8'h78;
        bus.month_bcd = 8'h06;
        bus.year_bcd  = 8'h4B;
        bus.blink_sel = 3'd0;

        // Reset held for 10 clocks: outputs stay at reset values
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst = 1'b0;

        // Frame 0: shadows are still zero, every slot shows '0'
        at_edge(1);  check_slot("f0_s0", 0, 7'h40, 1'b0);
        at_edge(6);  check_slot("f0_s1", 1, 7'h40, 1'b0);
        at_edge(18); check_slot("f0_s4", 4, 7'h40, 1'b0);
        at_edge(46); check("fd_before", 32'(bus.frame_done), 32'h0);
                     check_slot("f0_s11", 11, 7'h40, 1'b0);
        at_edge(47); check("fd_wrap",   32'(bus.frame_done), 32'h1);
        at_edge(48); check("fd_after",  32'(bus.frame_done), 32'h0);

        // Frame 1: captured snapshot (min still 12)
        at_edge(50); check_slot("f1_s0", 0, 7'h10, 1'b0);   // 9
        at_edge(54); check_slot("f1_s1", 1, 7'h12, 1'b0);   // 5
        at_edge(58); check_slot("f1_s2", 2, 7'h24, 1'b0);   // 2
        bus.min_bcd = 8'h34;                                // mid-frame change
        at_edge(62); check_slot("f1_s3", 3, 7'h79, 1'b0);   // still 1
        at_edge(66); check_slot("f1_s4", 4, 7'h30, 1'b0);   // 3
        at_edge(70); check_slot("f1_s5", 5, 7'h3F, 1'b0);   // A -> dash
        at_edge(74); check_slot("f1_s6", 6, 7'h00, 1'b0);   // 8
        at_edge(78); check_slot("f1_s7", 7, 7'h78, 1'b0);   // 7
        at_edge(82); check_slot("f1_s8", 8, 7'h02, 1'b0);   // 6
        at_edge(86); check_slot("f1_s9", 9, 7'h40, 1'b0);   // 0
        at_edge(90); check_slot("f1_s10", 10, 7'h3F, 1'b0); // B -> dash
        at_edge(94); check_slot("f1_s11", 11, 7'h19, 1'b0); // 4
        bus.blink_sel = 3'd3;                               // hour

        // Frame 2: new minutes visible, blink phase 1 blanks hour slots
        at_edge(106); check_slot("f2_s2", 2, 7'h19, 1'b0);  // 4
        at_edge(110); check_slot("f2_s3", 3, 7'h30, 1'b0);  // 3
        at_edge(114); check_slot("f2_s4", 4, 7'h30, BLINK_ON);
        at_edge(118); check_slot("f2_s5", 5, 7'h3F, BLINK_ON);
        at_edge(122); check_slot("f2_s6", 6, 7'h00, 1'b0);

        // Frame 3: still phase 1; blink_sel 7 means none, then back to hour
        at_edge(146); check_slot("f3_s0", 0, 7'h10, 1'b0);
        bus.blink_sel = 3'd7;
        at_edge(162); check_slot("f3_s4_sel7", 4, 7'h30, 1'b0);
        bus.blink_sel = 3'd3;
        at_edge(166); check_slot("f3_s5_sel3", 5, 7'h3F, BLINK_ON);

        // Frame 4: phase back to 0, hour visible again
        at_edge(210); check_slot("f4_s4", 4, 7'h30, 1'b0);
        at_edge(214); check_slot("f4_s5", 5, 7'h3F, 1'b0);
        bus.blink_sel = 3'd0;

        // Asynchronous reset in the middle of slot 7
        at_edge(222); check_slot("f4_s7", 7, 7'h78, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;

        // Restart from slot 0 with zeroed shadows (sec input is still 59)
        at_edge(1);  check_slot("rs_s0", 0, 7'h40, 1'b0);
        at_edge(6);  check_slot("rs_s1", 1, 7'h40, 1'b0);
        at_edge(47); check("rs_fd", 32'(bus.frame_done), 32'h1);
        at_edge(50); check_slot("rs_f1_s0", 0, 7'h10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
